// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - glyph patterns and BCD digit types for the 7-segment scanner
package seg7_pkg;

  // One BCD digit and the four-digit word (index 3 = thousands, 0 = ones)
  typedef logic [3:0] bcd_digit_t;
  typedef bcd_digit_t [3:0] bcd_quad_t;

  // Glyphs in active-high form, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG7_0     = 7'h3F;
  localparam logic [6:0] SEG7_1     = 7'h06;
  localparam logic [6:0] SEG7_2     = 7'h5B;
  localparam logic [6:0] SEG7_3     = 7'h4F;
  localparam logic [6:0] SEG7_4     = 7'h66;
  localparam logic [6:0] SEG7_5     = 7'h6D;
  localparam logic [6:0] SEG7_6     = 7'h7D;
  localparam logic [6:0] SEG7_7     = 7'h07;
  localparam logic [6:0] SEG7_8     = 7'h7F;
  localparam logic [6:0] SEG7_9     = 7'h6F;
  localparam logic [6:0] SEG7_DASH  = 7'h40;
  localparam logic [6:0] SEG7_BLANK = 7'h00;

  // Number of scanned digits
  localparam int NUM_DIGITS = 4;

endpackage

// File: rtl/bcd_seg7_scanner_if.sv
// rtl/bcd_seg7_scanner_if.sv - digit/load inputs and display pin outputs of the scanner
interface bcd_seg7_scanner_if;
  import seg7_pkg::*;

  bcd_digit_t  thousands;
  bcd_digit_t  hundreds;
  bcd_digit_t  tens;
  bcd_digit_t  ones;
  logic        load;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame_done;

  // Upstream converter / test driver side
  modport master (
    output thousands, hundreds, tens, ones, load,
    input  seg, dp, an, frame_done
  );

  // Scanner side
  modport slave (
    input  thousands, hundreds, tens, ones, load,
    output seg, dp, an, frame_done
  );

endinterface

// File: rtl/bcd_to_seg7.sv
// rtl/bcd_to_seg7.sv - combinational BCD to active-high 7-segment glyph decoder
module bcd_to_seg7
  import seg7_pkg::*;
(
  input  bcd_digit_t  bcd,
  output logic [6:0]  seg
);

  // Codes 10-15 never come from the converter; a dash makes them visible if they do
  always_comb begin
    seg = SEG7_DASH;
    case (bcd)
      4'd0:    seg = SEG7_0;
      4'd1:    seg = SEG7_1;
      4'd2:    seg = SEG7_2;
      4'd3:    seg = SEG7_3;
      4'd4:    seg = SEG7_4;
      4'd5:    seg = SEG7_5;
      4'd6:    seg = SEG7_6;
      4'd7:    seg = SEG7_7;
      4'd8:    seg = SEG7_8;
      4'd9:    seg = SEG7_9;
      default: seg = SEG7_DASH;
    endcase
  end

endmodule

// File: rtl/bcd_seg7_scanner.sv
// rtl/bcd_seg7_scanner.sv - 4-digit multiplexed 7-segment scanner; option LEADING_ZERO_BLANK_EN
module bcd_seg7_scanner
  import seg7_pkg::*;
#(
  parameter int REFRESH_DIV    = 50000,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int AN_ACTIVE_LOW  = 1
) (
  input  logic                clk,
  input  logic                rst,
  bcd_seg7_scanner_if.slave   bus
);

  localparam int             CW         = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0]  DIV_LAST   = CW'(REFRESH_DIV - 1);
  localparam logic           SEG_INV    = (SEG_ACTIVE_LOW != 0);
  localparam logic           AN_INV     = (AN_ACTIVE_LOW != 0);
  localparam logic [6:0]     SEG_UNLIT  = {7{SEG_INV}};
  localparam logic [3:0]     AN_OFF     = {4{AN_INV}};

  logic [CW-1:0] div_cnt;
  logic [1:0]    idx;
  logic          tc;
  logic          wrap;

  bcd_quad_t     din;
  bcd_quad_t     pend;
  bcd_quad_t     disp;
  logic          pend_vld;

  bcd_digit_t    cur_digit;
  logic [6:0]    glyph;
  logic [6:0]    lit;
  logic          blank;
  logic [3:0]    an_onehot;

  logic [6:0]    seg_q;
  logic [3:0]    an_q;
  logic          dp_q;
  logic          frame_done_q;

  assign din  = {bus.thousands, bus.hundreds, bus.tens, bus.ones};
  assign tc   = (div_cnt == DIV_LAST);
  assign wrap = tc && (idx == 2'd3);

  // Refresh divider and digit scan index; idx only moves on the divider terminal count
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
      idx     <= 2'd0;
    end else begin
      if (tc) begin
        div_cnt <= '0;
        idx     <= idx + 2'd1;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
    end
  end

  // Pending/display pair: loads land in pend, disp only changes at a frame wrap so digits never tear
  always_ff @(posedge clk) begin
    if (rst) begin
      pend     <= '0;
      disp     <= '0;
      pend_vld <= 1'b0;
    end else begin
      if (bus.load) begin
        pend <= din;
      end
      if (wrap && bus.load) begin
        disp     <= din;
        pend_vld <= 1'b0;
      end else if (wrap && pend_vld) begin
        disp     <= pend;
        pend_vld <= 1'b0;
      end else if (bus.load) begin
        pend_vld <= 1'b1;
      end
    end
  end

  assign cur_digit = disp[idx];

  bcd_to_seg7 u_dec (
    .bcd (cur_digit),
    .seg (glyph)
  );

`ifdef LEADING_ZERO_BLANK_EN
  logic [3:0] lead_zero;

  // A digit is a leading zero when it and every higher digit of disp are zero; ones never blanks
  always_comb begin
    lead_zero    = 4'b0000;
    lead_zero[3] = (disp[3] == 4'd0);
    lead_zero[2] = lead_zero[3] && (disp[2] == 4'd0);
    lead_zero[1] = lead_zero[2] && (disp[1] == 4'd0);
    lead_zero[0] = 1'b0;
    blank        = lead_zero[idx];
  end
`else
  assign blank = 1'b0;
`endif

  assign lit       = blank ? SEG7_BLANK : glyph;
  assign an_onehot = 4'b0001 << idx;

  // Pin registers; the only place panel polarity is applied
  always_ff @(posedge clk) begin
    if (rst) begin
      seg_q        <= SEG_UNLIT;
      an_q         <= AN_OFF;
      dp_q         <= SEG_INV;
      frame_done_q <= 1'b0;
    end else begin
      seg_q        <= lit ^ {7{SEG_INV}};
      an_q         <= an_onehot ^ {4{AN_INV}};
      dp_q         <= SEG_INV;
      frame_done_q <= wrap;
    end
  end

  assign bus.seg        = seg_q;
  assign bus.an         = an_q;
  assign bus.dp         = dp_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_bcd_seg7_scanner.sv
// tb/tb_bcd_seg7_scanner.sv - directed self-checking bench for bcd_seg7_scanner (REFRESH_DIV=4)
module tb_bcd_seg7_scanner;

  logic clk;
  logic rst;
  int   k;
  int   n_checks;
  int   n_errors;

  // Expected seg for a zero digit above the ones place (blanked when the option is built in)
`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [6:0] SEG_ZHI = 7'h7F;
`else
  localparam logic [6:0] SEG_ZHI = 7'h40;
`endif

  bcd_seg7_scanner_if bus_if ();

  bcd_seg7_scanner #(
    .REFRESH_DIV    (4),
    .SEG_ACTIVE_LOW (1),
    .AN_ACTIVE_LOW  (1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (obs !== exp) begin
      n_errors = n_errors + 1;
      $display("FAIL %s: got %0h expected %0h (k=%0d)", tag, obs, exp, k);
    end
  endtask

  // One rising edge, then settle at the falling edge where outputs are sampled and inputs driven
  task automatic tick();
    @(posedge clk);
    k = k + 1;
    @(negedge clk);
  endtask

  // Advance to the next cycle whose position within the 16-cycle frame is m
  task automatic wait_k(input int m);
    do tick(); while ((k % 16) != m);
  endtask

  task automatic do_load(input logic [3:0] th, input logic [3:0] hu,
                         input logic [3:0] te, input logic [3:0] on);
    bus_if.thousands = th;
    bus_if.hundreds  = hu;
    bus_if.tens      = te;
    bus_if.ones      = on;
    bus_if.load      = 1'b1;
    tick();
    bus_if.load      = 1'b0;
  endtask

  task automatic check_reset_pins(input string tag);
    check_eq({tag, "_an"},  {28'd0, bus_if.an},  32'hF);
    check_eq({tag, "_seg"}, {25'd0, bus_if.seg}, 32'h7F);
    check_eq({tag, "_dp"},  {31'd0, bus_if.dp},  32'h1);
    check_eq({tag, "_fd"},  {31'd0, bus_if.frame_done}, 32'h0);
  endtask

  task automatic check_pins(input string tag, input logic [3:0] an_e, input logic [6:0] seg_e);
    check_eq({tag, "_an"},  {28'd0, bus_if.an},  {28'd0, an_e});
    check_eq({tag, "_seg"}, {25'd0, bus_if.seg}, {25'd0, seg_e});
  endtask

  initial begin
    n_checks         = 0;
    n_errors         = 0;
    k                = 0;
    rst              = 1'b1;
    bus_if.thousands = 4'd0;
    bus_if.hundreds  = 4'd0;
    bus_if.tens      = 4'd0;
    bus_if.ones      = 4'd0;
    bus_if.load      = 1'b0;

    // T1: reset, release, scan cadence
    tick(); tick(); tick();
    check_reset_pins("t1_inrst");
    rst = 1'b0;
    k   = -1;
    #1;
    check_reset_pins("t1_rel0");
    tick();
    check_pins("t1_rel1", 4'b1110, 7'h40);
    check_eq("t1_dp", {31'd0, bus_if.dp}, 32'h1);
    check_eq("t1_fd0", {31'd0, bus_if.frame_done}, 32'h0);
    wait_k(3);  check_pins("t1_d0_end", 4'b1110, 7'h40);
    wait_k(4);  check_pins("t1_d1", 4'b1101, SEG_ZHI);
    wait_k(8);  check_pins("t1_d2", 4'b1011, SEG_ZHI);
    wait_k(12); check_pins("t1_d3", 4'b0111, SEG_ZHI);
    wait_k(14); check_eq("t1_fd14", {31'd0, bus_if.frame_done}, 32'h0);
    wait_k(15); check_eq("t1_fd15", {31'd0, bus_if.frame_done}, 32'h1);
    tick();     check_eq("t1_fd16", {31'd0, bus_if.frame_done}, 32'h0);
    check_pins("t1_wrap_d0", 4'b1110, 7'h40);

    // T2: load 1234 while idx=1; old value kept until wrap
    wait_k(4);
    do_load(4'd1, 4'd2, 4'd3, 4'd4);
    wait_k(8);  check_pins("t2_pre_d2", 4'b1011, SEG_ZHI);
    wait_k(15); check_pins("t2_pre_d3", 4'b0111, SEG_ZHI);
    check_eq("t2_fd", {31'd0, bus_if.frame_done}, 32'h1);
    wait_k(0);  check_pins("t2_d0", 4'b1110, 7'h19);
    wait_k(4);  check_pins("t2_d1", 4'b1101, 7'h30);
    wait_k(8);  check_pins("t2_d2", 4'b1011, 7'h24);
    wait_k(12); check_pins("t2_d3", 4'b0111, 7'h79);

    // T3: 5678 then 9012 before the wrap; last load wins
    wait_k(1);
    do_load(4'd5, 4'd6, 4'd7, 4'd8);
    wait_k(9);
    do_load(4'd9, 4'd0, 4'd1, 4'd2);
    wait_k(0);  check_pins("t3_d0", 4'b1110, 7'h24);
    wait_k(4);  check_pins("t3_d1", 4'b1101, 7'h79);
    wait_k(8);  check_pins("t3_d2", 4'b1011, 7'h40);
    wait_k(12); check_pins("t3_d3", 4'b0111, 7'h10);

    // T4: load 0007 sampled on the wrap edge itself
    wait_k(14);
    do_load(4'd0, 4'd0, 4'd0, 4'd7);
    check_eq("t4_pend_vld", {31'd0, dut.pend_vld}, 32'h0);
    tick();     check_pins("t4_d0", 4'b1110, 7'h78);
    wait_k(4);  check_pins("t4_d1", 4'b1101, SEG_ZHI);
    wait_k(12); check_pins("t4_d3", 4'b0111, SEG_ZHI);

    // T5: illegal code 0xC on tens shows a dash
    wait_k(5);
    do_load(4'd0, 4'd0, 4'hC, 4'd0);
    wait_k(0);  check_pins("t5_d0", 4'b1110, 7'h40);
    wait_k(4);  check_pins("t5_dash", 4'b1101, 7'h3F);
    wait_k(8);  check_pins("t5_d2", 4'b1011, SEG_ZHI);

    // T6: 0042 then 0000, leading-zero handling
    wait_k(5);
    do_load(4'd0, 4'd0, 4'd4, 4'd2);
    wait_k(0);  check_pins("t6_d0", 4'b1110, 7'h24);
    wait_k(4);  check_pins("t6_d1", 4'b1101, 7'h19);
    wait_k(8);  check_pins("t6_d2", 4'b1011, SEG_ZHI);
    wait_k(12); check_pins("t6_d3", 4'b0111, SEG_ZHI);
    wait_k(5);
    do_load(4'd0, 4'd0, 4'd0, 4'd0);
    wait_k(0);  check_pins("t6_z_d0", 4'b1110, 7'h40);
    wait_k(4);  check_pins("t6_z_d1", 4'b1101, SEG_ZHI);

    // T7: reset clears the shown value and discards a pending load
    wait_k(5);
    do_load(4'd8, 4'd8, 4'd8, 4'd8);
    wait_k(0);  check_pins("t7_d0", 4'b1110, 7'h00);
    wait_k(12); check_pins("t7_d3", 4'b0111, 7'h00);
    wait_k(5);
    do_load(4'd9, 4'd9, 4'd9, 4'd9);
    rst = 1'b1;
    tick(); tick();
    check_reset_pins("t7_inrst");
    rst = 1'b0;
    k   = -1;
    #1;
    check_reset_pins("t7_rel0");
    tick();     check_pins("t7_rel1", 4'b1110, 7'h40);
    wait_k(12); check_pins("t7_post_d3", 4'b0111, SEG_ZHI);
    wait_k(15); check_eq("t7_fd", {31'd0, bus_if.frame_done}, 32'h1);
    wait_k(0);  check_pins("t7_nopend_d0", 4'b1110, 7'h40);
    wait_k(4);  check_pins("t7_nopend_d1", 4'b1101, SEG_ZHI);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
